// File: rtl/dma_pcis_read_responder_pkg.sv
// Shared types and constants for the DMA PCIS outbound read responder.
package dma_pcis_read_responder_pkg;

  localparam int unsigned PCIS_DATA_W = 512;
  localparam int unsigned PCIS_ID_W   = 6;
  localparam int unsigned PCIS_LEN_W  = 8;
  localparam int unsigned PCIS_REM_W  = 9;

  localparam logic [2:0] PCIS_SIZE_64B    = 3'd6;
  localparam logic [1:0] PCIS_RESP_OKAY   = 2'b00;
  localparam logic [1:0] PCIS_RESP_SLVERR = 2'b10;

  localparam int unsigned F1_PCIS_OUT_FIFO_Depth = 16;
  localparam int unsigned F1_PCIS_AR_FIFO_Depth  = 4;

  // One outbound packet is exactly one R beat.
  typedef logic [PCIS_DATA_W-1:0] F1_PCIS_OUT_FIFO_Type;

  // Pending read request; bad marks an unsupported beat size.
  typedef struct packed {
    logic [PCIS_ID_W-1:0]  id;
    logic [PCIS_LEN_W-1:0] len;
    logic                  bad;
  } F1_PCIS_AR_FIFO_Type;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } rd_fsm_state;

  // AXI len is beats minus one; 255 must become 256, hence the extra bit.
  function automatic logic [PCIS_REM_W-1:0] burst_beats(input logic [PCIS_LEN_W-1:0] len);
    return {1'b0, len} + 9'd1;
  endfunction

  function automatic logic size_is_bad(input logic [2:0] size);
    return size != PCIS_SIZE_64B;
  endfunction

endpackage

// File: rtl/dma_pcis_read_responder_if.sv
// AXI-4 read address and read data channels of the DMA PCIS port.
interface dma_pcis_read_responder_if;
  import dma_pcis_read_responder_pkg::*;

  logic [PCIS_ID_W-1:0]   sh_cl_dma_pcis_arid;
  logic [63:0]            sh_cl_dma_pcis_araddr;
  logic [PCIS_LEN_W-1:0]  sh_cl_dma_pcis_arlen;
  logic [2:0]             sh_cl_dma_pcis_arsize;
  logic                   sh_cl_dma_pcis_arvalid;
  logic                   cl_sh_dma_pcis_arready;
  logic [PCIS_ID_W-1:0]   cl_sh_dma_pcis_rid;
  logic [PCIS_DATA_W-1:0] cl_sh_dma_pcis_rdata;
  logic [1:0]             cl_sh_dma_pcis_rresp;
  logic                   cl_sh_dma_pcis_rlast;
  logic                   cl_sh_dma_pcis_rvalid;
  logic                   sh_cl_dma_pcis_rready;

  // Shell side: issues requests and accepts beats.
  modport master (
    output sh_cl_dma_pcis_arid, sh_cl_dma_pcis_araddr, sh_cl_dma_pcis_arlen,
           sh_cl_dma_pcis_arsize, sh_cl_dma_pcis_arvalid, sh_cl_dma_pcis_rready,
    input  cl_sh_dma_pcis_arready, cl_sh_dma_pcis_rid, cl_sh_dma_pcis_rdata,
           cl_sh_dma_pcis_rresp, cl_sh_dma_pcis_rlast, cl_sh_dma_pcis_rvalid
  );

  // Card side: accepts requests and returns beats.
  modport slave (
    input  sh_cl_dma_pcis_arid, sh_cl_dma_pcis_araddr, sh_cl_dma_pcis_arlen,
           sh_cl_dma_pcis_arsize, sh_cl_dma_pcis_arvalid, sh_cl_dma_pcis_rready,
    output cl_sh_dma_pcis_arready, cl_sh_dma_pcis_rid, cl_sh_dma_pcis_rdata,
           cl_sh_dma_pcis_rresp, cl_sh_dma_pcis_rlast, cl_sh_dma_pcis_rvalid
  );

endinterface

// File: rtl/dma_pcis_read_responder_fifo.sv
// HullFIFO: show-ahead synchronous FIFO with full/empty flags.
// Enqueue while full and dequeue while empty are ignored.
module HullFIFO #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LOG_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_i,
  input  logic [WIDTH-1:0] enq_data_i,
  input  logic             deq_i,
  output logic [WIDTH-1:0] deq_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned          DEPTH   = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0]   CNT_MAX = (LOG_DEPTH + 1)'(DEPTH);
  localparam logic [LOG_DEPTH:0]   CNT_ONE = (LOG_DEPTH + 1)'(1);
  localparam logic [LOG_DEPTH-1:0] PTR_ONE = LOG_DEPTH'(1);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q;
  logic [LOG_DEPTH-1:0] rd_ptr_q;
  logic [LOG_DEPTH:0]   count_q;
  logic                 do_enq_s;
  logic                 do_deq_s;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CNT_MAX);
  assign do_enq_s   = enq_i && !full_o;
  assign do_deq_s   = deq_i && !empty_o;
  assign deq_data_o = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_enq_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_deq_s) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_enq_s, do_deq_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_enq_s) mem_q[wr_ptr_q] <= enq_data_i;
  end

endmodule

// File: rtl/dma_pcis_read_responder_r_out_stage.sv
// Single-entry registered R channel output with load/hold handshake.
module dma_pcis_r_out_stage
  import dma_pcis_read_responder_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic [PCIS_DATA_W-1:0] data_i,
  input  logic [PCIS_ID_W-1:0]   id_i,
  input  logic [1:0]             resp_i,
  input  logic                   last_i,
  input  logic                   rready_i,
  output logic                   loadable_o,
  output logic                   rvalid_o,
  output logic [PCIS_DATA_W-1:0] rdata_o,
  output logic [PCIS_ID_W-1:0]   rid_o,
  output logic [1:0]             rresp_o,
  output logic                   rlast_o
);

  logic                   rvalid_q, rvalid_d;
  logic [PCIS_DATA_W-1:0] rdata_q,  rdata_d;
  logic [PCIS_ID_W-1:0]   rid_q,    rid_d;
  logic [1:0]             rresp_q,  rresp_d;
  logic                   rlast_q,  rlast_d;

  // Loadable when empty or when the current beat leaves this cycle.
  assign loadable_o = !rvalid_q || rready_i;

  // Next register contents: load a new beat, retire the old one, or hold.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rid_d    = rid_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    if (load_i && loadable_o) begin
      rvalid_d = 1'b1;
      rdata_d  = data_i;
      rid_d    = id_i;
      rresp_d  = resp_i;
      rlast_d  = last_i;
    end else if (rready_i) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
  end

  // Output register; reset clears every field.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
      rresp_q  <= 2'b00;
      rlast_q  <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rid_q    <= rid_d;
      rresp_q  <= rresp_d;
      rlast_q  <= rlast_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign rid_o    = rid_q;
  assign rresp_o  = rresp_q;
  assign rlast_o  = rlast_q;

endmodule

// File: rtl/dma_pcis_read_responder.sv
// Answers shell AXI-4 read bursts with packets from the outbound FIFO.
// Bad sizes and starved bursts are completed with SLVERR zero beats.
module dma_pcis_read_responder
  import dma_pcis_read_responder_pkg::*;
#(
  parameter int unsigned OUT_FIFO_LOG_DEPTH = $clog2(F1_PCIS_OUT_FIFO_Depth),
  parameter int unsigned AR_FIFO_LOG_DEPTH  = $clog2(F1_PCIS_AR_FIFO_Depth),
  parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  dma_pcis_read_responder_if.slave   pcis,
  input  logic [PCIS_DATA_W-1:0]     shell_pcie_out_packet,
  input  logic                       shell_pcie_out_packet_valid,
  output logic                       shell_pcie_out_packet_grant,
  output logic [31:0]                rd_err_beats
);

  localparam int unsigned     TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  // Outbound packet FIFO
  logic                 out_full_s, out_empty_s, out_deq_s;
  F1_PCIS_OUT_FIFO_Type out_head_s;

  // Pending request FIFO
  logic                 ar_full_s, ar_empty_s, ar_enq_s, ar_deq_s;
  F1_PCIS_AR_FIFO_Type  ar_in_s, ar_head_s;

  // Burst sequencer
  rd_fsm_state          state_q, state_d;
  logic [PCIS_ID_W-1:0] id_q, id_d;
  logic [PCIS_REM_W-1:0] rem_q, rem_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;

  // Beat handed to the output register
  logic                   loadable_s, ld_s, ld_last_s;
  logic [PCIS_DATA_W-1:0] ld_data_s;
  logic [1:0]             ld_resp_s;

  logic [31:0] err_cnt_q, err_cnt_d;
  logic        err_beat_s;
  logic        unused_araddr_s;

  assign unused_araddr_s = ^pcis.sh_cl_dma_pcis_araddr;

  assign shell_pcie_out_packet_grant = shell_pcie_out_packet_valid && !out_full_s;

  HullFIFO #(.WIDTH(PCIS_DATA_W), .LOG_DEPTH(OUT_FIFO_LOG_DEPTH)) u_out_fifo (
    .clk        (clk),
    .rst        (rst),
    .enq_i      (shell_pcie_out_packet_grant),
    .enq_data_i (shell_pcie_out_packet),
    .deq_i      (out_deq_s),
    .deq_data_o (out_head_s),
    .empty_o    (out_empty_s),
    .full_o     (out_full_s)
  );

  assign pcis.cl_sh_dma_pcis_arready = !ar_full_s && !rst;
  assign ar_enq_s = pcis.sh_cl_dma_pcis_arvalid && pcis.cl_sh_dma_pcis_arready;
  assign ar_in_s  = '{id:  pcis.sh_cl_dma_pcis_arid,
                      len: pcis.sh_cl_dma_pcis_arlen,
                      bad: size_is_bad(pcis.sh_cl_dma_pcis_arsize)};

  HullFIFO #(.WIDTH($bits(F1_PCIS_AR_FIFO_Type)), .LOG_DEPTH(AR_FIFO_LOG_DEPTH)) u_ar_fifo (
    .clk        (clk),
    .rst        (rst),
    .enq_i      (ar_enq_s),
    .enq_data_i (ar_in_s),
    .deq_i      (ar_deq_s),
    .deq_data_o (ar_head_s),
    .empty_o    (ar_empty_s),
    .full_o     (ar_full_s)
  );

  // Sequencer: pick up the next request, then stream data or error beats.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    rem_d     = rem_q;
    tmo_d     = tmo_q;
    ar_deq_s  = 1'b0;
    out_deq_s = 1'b0;
    ld_s      = 1'b0;
    ld_data_s = '0;
    ld_resp_s = PCIS_RESP_OKAY;
    ld_last_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ar_empty_s) begin
          ar_deq_s = 1'b1;
          id_d     = ar_head_s.id;
          rem_d    = burst_beats(ar_head_s.len);
          tmo_d    = '0;
          state_d  = ar_head_s.bad ? DRAIN : BURST;
        end else begin
          state_d  = IDLE;
        end
      end
      BURST: begin
        if (loadable_s && !out_empty_s) begin
          ld_s      = 1'b1;
          ld_data_s = out_head_s;
          ld_resp_s = PCIS_RESP_OKAY;
          ld_last_s = (rem_q == 9'd1);
          out_deq_s = 1'b1;
          rem_d     = rem_q - 9'd1;
          tmo_d     = '0;
          state_d   = (rem_q == 9'd1) ? IDLE : BURST;
        end else if (loadable_s && (tmo_q == TMO_LAST)) begin
          tmo_d     = '0;
          state_d   = DRAIN;
        end else if (loadable_s) begin
          tmo_d     = tmo_q + TMO_ONE;
        end else begin
          state_d   = BURST;
        end
      end
      DRAIN: begin
        if (loadable_s) begin
          ld_s      = 1'b1;
          ld_data_s = '0;
          ld_resp_s = PCIS_RESP_SLVERR;
          ld_last_s = (rem_q == 9'd1);
          rem_d     = rem_q - 9'd1;
          state_d   = (rem_q == 9'd1) ? IDLE : DRAIN;
        end else begin
          state_d   = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      rem_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      rem_q   <= rem_d;
      tmo_q   <= tmo_d;
    end
  end

  dma_pcis_r_out_stage u_r_out (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ld_s),
    .data_i     (ld_data_s),
    .id_i       (id_q),
    .resp_i     (ld_resp_s),
    .last_i     (ld_last_s),
    .rready_i   (pcis.sh_cl_dma_pcis_rready),
    .loadable_o (loadable_s),
    .rvalid_o   (pcis.cl_sh_dma_pcis_rvalid),
    .rdata_o    (pcis.cl_sh_dma_pcis_rdata),
    .rid_o      (pcis.cl_sh_dma_pcis_rid),
    .rresp_o    (pcis.cl_sh_dma_pcis_rresp),
    .rlast_o    (pcis.cl_sh_dma_pcis_rlast)
  );

  assign err_beat_s = pcis.cl_sh_dma_pcis_rvalid && pcis.sh_cl_dma_pcis_rready &&
                      (pcis.cl_sh_dma_pcis_rresp == PCIS_RESP_SLVERR);

  // Saturating count of delivered SLVERR beats.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_beat_s && (err_cnt_q != 32'hFFFF_FFFF)) begin
      err_cnt_d = err_cnt_q + 32'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 32'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign rd_err_beats = err_cnt_q;

endmodule
